probe_capture_buffer: RTL and testbench
=======================================

// Module: probe_capture_buffer
// PURPOSE
//  Parametrised on-chip logic-analyser capture core for UDP datapath debug.
//  Records a DATA_W-wide probe bus into a circular buffer with a fixed pre-trigger window.
//  Triggers on a masked pattern match, then stops after the post-trigger window.
//  Exposes a 1-cycle-latency readout port, indexed from the oldest stored sample.
// PARAMETERS
//  DATA_W    48    total probe width (concatenated probe channels), >=1
//  DEPTH     1024  buffer depth in samples, power of 2, >=4; AW = $clog2(DEPTH)
//  PRE_TRIG  256   samples kept before trigger sample, 0 <= PRE_TRIG < DEPTH
// PORTS
//  clk         in   1       sample/system clock
//  rst_n       in   1       asynchronous active-low reset
//  probe_data  in   DATA_W  probe bus sampled every clk
//  arm         in   1       1-cycle start pulse; honoured only in IDLE or DONE
//  abort       in   1       return to IDLE from any state; wins over arm
//  trig_mask   in   DATA_W  1 = bit participates in compare; hold stable while armed
//  trig_value  in   DATA_W  compare pattern
//  busy        out  1       state is PRE, ARMED or POST
//  triggered   out  1       trigger seen in current run (POST or DONE)
//  done        out  1       state is DONE; buffer readable
//  trig_addr   out  AW      physical buffer address of trigger sample
//  rd_en       in   1       read request; ignored unless done=1
//  rd_addr     in   AW      logical index: 0 = oldest, PRE_TRIG = trigger sample
//  rd_data     out  DATA_W  sample for rd_addr, valid with rd_valid
//  rd_valid    out  1       asserted exactly 1 cycle after an accepted rd_en
// BEHAVIOUR
//  Reset: state IDLE; busy, triggered, done, rd_valid = 0; trig_addr, rd_data = 0; wr_ptr = 0.
//    Buffer RAM is not reset. Reset mid-run discards the run entirely.
//  States: IDLE -> PRE -> ARMED -> POST -> DONE; DONE -> PRE on arm.
//  IDLE: arm -> PRE next cycle, wr_ptr = 0, counters cleared. First sample is written in the cycle after arm.
//  PRE: write probe_data at wr_ptr, wr_ptr++; after PRE_TRIG writes -> ARMED.
//    Trigger is ignored in PRE, so the pre-window is always full. PRE_TRIG = 0: arm goes directly to ARMED.
//  ARMED: write every cycle; wr_ptr wraps modulo DEPTH (unbounded wait).
//    Match when ((probe_data ^ trig_value) & trig_mask) == 0; trig_mask = 0 matches on the first ARMED cycle.
//    On match, the matching sample is written; trig_addr <= wr_ptr; triggered <= 1; state -> POST.
//  POST: write until DEPTH-PRE_TRIG samples, trigger included, are stored -> DONE.
//    No writes in DONE.
//  Readout: phys = (trig_addr - PRE_TRIG + rd_addr) mod DEPTH; rd_data registered, latency 1.
//    Back-to-back rd_en is allowed, giving 1 sample/cycle.
//  abort: any state -> IDLE next cycle; busy, triggered and done cleared. In-flight read completes.
//  arm while busy: ignored. arm in DONE: clears done/triggered and restarts PRE.
//  Total latency from trigger sample to done=1: DEPTH-PRE_TRIG cycles.
// CONFIGURATION
//  PROBE_CAPTURE_QUAL_EN defined: adds input port qual (1 bit, after probe_data).
//    Writes, wr_ptr and all counters advance, and the trigger is evaluated, only in cycles with qual=1.
//    Windows count qualified samples.
//  PROBE_CAPTURE_QUAL_EN undefined: no qual port; every cycle is qualified.
// TESTING (bench: DATA_W=8, DEPTH=16, PRE_TRIG=4, probe_data = free-running 8-bit counter)
//  1 mask=0xFF, value=0x30, arm while probe=0x1F -> done=1 one cycle after sample 0x3B.
//    Reads 0..15 return 0x2C..0x3B; rd_addr 4 = 0x30; rd_valid 1 cycle after each rd_en.
//  2 mask=0x00, arm while probe=0x50 -> PRE stores 0x51..0x54; trigger on 0x55.
//    triggered=1 in next cycle; rd_addr 4 = 0x55.
//  3 mask=0xFF, value=0x80, arm while probe=0x3F -> many wraps in ARMED.
//    Readout is contiguous 0x7C..0x8B; trig_addr = (0x80-0x40) mod 16 = 0.
//  4 abort 3 cycles into ARMED -> IDLE next cycle, busy=0, done=0.
//    arm+abort in the same cycle from IDLE -> stays IDLE.
//  5 rst_n low mid-POST -> all outputs 0 asynchronously; after release, arm starts a clean run identical to test 1.
//  6 QUAL_EN: qual = probe[0], value=0x31, arm at 0x1F -> stored 0x29,0x2B,...,0x47; rd_addr 4 = 0x31.
//    rd_en while busy -> rd_valid stays 0.

Source files
------------

// File: rtl/probe_capture_buffer.sv
// Logic-analyser capture core: circular buffer with a fixed pre-trigger window and masked trigger.
// Define PROBE_CAPTURE_QUAL_EN to add the qual input (only qualified cycles are sampled/counted).
module probe_capture_buffer #(
  parameter int DATA_W   = 48,
  parameter int DEPTH    = 1024,
  parameter int PRE_TRIG = 256,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] probe_data,
`ifdef PROBE_CAPTURE_QUAL_EN
  input  logic              qual,
`endif
  input  logic              arm,
  input  logic              abort,
  input  logic [DATA_W-1:0] trig_mask,
  input  logic [DATA_W-1:0] trig_value,
  output logic              busy,
  output logic              triggered,
  output logic              done,
  output logic [AW-1:0]     trig_addr,
  input  logic              rd_en,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid
);

  typedef enum logic [2:0] {S_IDLE, S_PRE, S_ARMED, S_POST, S_DONE} state_e;

  localparam int POST_N      = DEPTH - PRE_TRIG;
  localparam int PRE_LAST_I  = (PRE_TRIG > 0) ? PRE_TRIG - 1 : 0;
  localparam int POST_LAST_I = POST_N - 1;
  localparam logic [AW:0]   PRE_LAST  = PRE_LAST_I[AW:0];
  localparam logic [AW:0]   POST_LAST = POST_LAST_I[AW:0];
  localparam logic [AW-1:0] PRE_OFS   = PRE_TRIG[AW-1:0];

  state_e              state_q, state_d;
  logic [AW:0]         cnt_q, cnt_d;
  logic [AW-1:0]       wr_ptr_q;
  logic [AW-1:0]       trig_addr_q;
  logic [DATA_W-1:0]   rd_data_q;
  logic                rd_valid_q;
  logic                wr_en, start, hit, qok, match;
  logic [AW-1:0]       phys;
  logic [DATA_W-1:0]   mem [DEPTH];

`ifdef PROBE_CAPTURE_QUAL_EN
  assign qok = qual;
`else
  assign qok = 1'b1;
`endif

  assign match = ((probe_data ^ trig_value) & trig_mask) == '0;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_en   = 1'b0;
    start   = 1'b0;
    hit     = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: if (arm) begin
        start   = 1'b1;
        cnt_d   = '0;
        state_d = (PRE_TRIG == 0) ? S_ARMED : S_PRE;
      end
      S_PRE: if (qok) begin
        wr_en = 1'b1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == PRE_LAST) begin
          cnt_d   = '0;
          state_d = S_ARMED;
        end
      end
      S_ARMED: if (qok) begin
        wr_en = 1'b1;
        if (match) begin
          hit     = 1'b1;
          // the trigger sample itself is the first of the post window
          cnt_d   = {{AW{1'b0}}, 1'b1};
          state_d = (POST_N == 1) ? S_DONE : S_POST;
        end
      end
      S_POST: if (qok) begin
        wr_en = 1'b1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == POST_LAST) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
    if (abort) begin
      state_d = S_IDLE;
      wr_en   = 1'b0;
      start   = 1'b0;
      hit     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  assign phys = trig_addr_q - PRE_OFS + rd_addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      wr_ptr_q    <= '0;
      trig_addr_q <= '0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      if (start)      wr_ptr_q <= '0;
      else if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (hit) trig_addr_q <= wr_ptr_q;
      rd_valid_q <= rd_en && (state_q == S_DONE);
      if (rd_en && (state_q == S_DONE)) rd_data_q <= mem[phys];
    end
  end

  // capture RAM is deliberately not reset
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q] <= probe_data;
  end

  assign busy      = (state_q == S_PRE) || (state_q == S_ARMED) || (state_q == S_POST);
  assign triggered = (state_q == S_POST) || (state_q == S_DONE);
  assign done      = (state_q == S_DONE);
  assign trig_addr = trig_addr_q;
  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;

endmodule

// File: tb/tb_probe_capture_buffer.sv
// Randomised and directed bench for probe_capture_buffer against a sample-history model.
module tb_probe_capture_buffer;
  localparam int DW = 8, DEPTH = 16, PRE = 4, AW = 4;

  logic clk = 1'b0, rst_n = 1'b0, arm = 1'b0, abort = 1'b0, rd_en = 1'b0;
  logic [DW-1:0] probe = '0, mask = '0, val = '0;
  logic [AW-1:0] rd_addr = '0;
  logic busy, triggered, done, rd_valid;
  logic [AW-1:0] trig_addr;
  logic [DW-1:0] rd_data;
`ifdef PROBE_CAPTURE_QUAL_EN
  wire qual = probe[0];
`endif

  probe_capture_buffer #(.DATA_W(DW), .DEPTH(DEPTH), .PRE_TRIG(PRE)) dut (
    .clk(clk), .rst_n(rst_n), .probe_data(probe),
`ifdef PROBE_CAPTURE_QUAL_EN
    .qual(qual),
`endif
    .arm(arm), .abort(abort), .trig_mask(mask), .trig_value(val),
    .busy(busy), .triggered(triggered), .done(done), .trig_addr(trig_addr),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid));

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;
  logic [DW-1:0] exp_buf [DEPTH];
  int exp_done, exp_trig_tick;
  logic [AW-1:0] exp_taddr;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // probe is a free-running counter, changed 1 time unit after each rising edge
  task automatic tick();
    @(posedge clk); #1;
    probe = probe + 1'b1;
  endtask

  function automatic bit qualified(input logic [DW-1:0] v);
`ifdef PROBE_CAPTURE_QUAL_EN
    return v[0];
`else
    return (v == v);
`endif
  endfunction

  // sample j after the arm edge has value p+j; collect qualified history and pick the window
  task automatic model(input logic [DW-1:0] p, input logic [DW-1:0] m, input logic [DW-1:0] v);
    logic [DW-1:0] hist [$];
    logic [DW-1:0] s;
    int trig;
    trig = -1; exp_done = -1; exp_trig_tick = -1;
    for (int j = 1; j < 3000; j++) begin
      s = p + 8'(j);
      if (!qualified(s)) continue;
      hist.push_back(s);
      if (trig < 0 && hist.size() - 1 >= PRE && ((s ^ v) & m) == 0) begin
        trig = hist.size() - 1;
        exp_trig_tick = j;
      end
      if (trig >= 0 && hist.size() == trig + DEPTH - PRE) begin
        exp_done = j;
        break;
      end
    end
    for (int i = 0; i < DEPTH; i++) exp_buf[i] = hist[trig - PRE + i];
    exp_taddr = 4'(trig % DEPTH);
  endtask

  task automatic wait_probe(input logic [DW-1:0] p);
    int n;
    n = 0;
    while (probe != p && n < 600) begin tick(); n++; end
    if (probe != p) chk("wait_probe", 32'(probe), 32'(p));
  endtask

  task automatic start_run(input logic [DW-1:0] p, input logic [DW-1:0] m, input logic [DW-1:0] v);
    model(p, m, v);
    mask = m; val = v;
    wait_probe(p);
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  task automatic run(input string nm, input logic [DW-1:0] p, input logic [DW-1:0] m,
                     input logic [DW-1:0] v);
    int n;
    start_run(p, m, v);
    rd_en = 1'b1;
    n = 0;
    while (n < 2000) begin
      tick(); n++;
      if (n == exp_trig_tick - 1) chk({nm, ".trig_pre"}, 32'(triggered), 0);
      if (n == exp_trig_tick)     chk({nm, ".trig_now"}, 32'(triggered), 1);
      chk({nm, ".rdv_busy"}, 32'(rd_valid), 0);
      if (done) break;
    end
    rd_en = 1'b0;
    chk({nm, ".done_tick"}, n, exp_done);
    chk({nm, ".trig_addr"}, 32'(trig_addr), 32'(exp_taddr));
    for (int i = 0; i < DEPTH; i++) begin
      rd_en = 1'b1; rd_addr = 4'(i);
      tick();
      chk({nm, ".rdv"}, 32'(rd_valid), 1);
      chk($sformatf("%s.rd%0d", nm, i), 32'(rd_data), 32'(exp_buf[i]));
    end
    rd_en = 1'b0;
    tick();
    chk({nm, ".rdv_idle"}, 32'(rd_valid), 0);
    for (int k = 0; k < 3; k++) begin
      rd_addr = 4'($urandom_range(DEPTH - 1));
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
      chk({nm, ".rnd_rd"}, 32'(rd_data), 32'(exp_buf[rd_addr]));
      tick();
      chk({nm, ".rnd_rdv"}, 32'(rd_valid), 0);
    end
  endtask

  initial begin
    logic [DW-1:0] rp, rm, rv;
    int n;
    tick(); tick();
    chk("rst.busy", 32'(busy), 0);
    chk("rst.trig", 32'(triggered), 0);
    chk("rst.done", 32'(done), 0);
    chk("rst.taddr", 32'(trig_addr), 0);
    chk("rst.rdata", 32'(rd_data), 0);
    chk("rst.rdv", 32'(rd_valid), 0);
    rst_n = 1'b1;
    tick();

    run("t1", 8'h1F, 8'hFF, 8'h30);
`ifdef PROBE_CAPTURE_QUAL_EN
    run("t6", 8'h1F, 8'hFF, 8'h31);
    run("t2", 8'h50, 8'h00, 8'h00);
    run("t3", 8'h3F, 8'hFF, 8'h81);
`else
    run("t2", 8'h50, 8'h00, 8'h00);
    run("t3", 8'h3F, 8'hFF, 8'h80);
`endif

    // abort a few cycles into ARMED; trigger value is far away
    start_run(8'h10, 8'hFF, 8'h75);
    for (int k = 0; k < 2 * PRE + 5; k++) tick();
    chk("abort.busy_before", 32'(busy), 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort.busy", 32'(busy), 0);
    chk("abort.done", 32'(done), 0);
    chk("abort.trig", 32'(triggered), 0);
    arm = 1'b1; abort = 1'b1;
    tick();
    arm = 1'b0; abort = 1'b0;
    chk("armabort.busy", 32'(busy), 0);
    tick();
    chk("armabort.busy2", 32'(busy), 0);

    // asynchronous reset during POST, then a clean repeat of the first run
    start_run(8'h1F, 8'hFF, 8'h31);
    n = 0;
    while (!triggered && n < 2000) begin tick(); n++; end
    chk("rstmid.in_post", 32'(triggered), 1);
    rst_n = 1'b0;
    #1;
    chk("rstmid.busy", 32'(busy), 0);
    chk("rstmid.trig", 32'(triggered), 0);
    chk("rstmid.done", 32'(done), 0);
    chk("rstmid.taddr", 32'(trig_addr), 0);
    chk("rstmid.rdv", 32'(rd_valid), 0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    run("t5", 8'h1F, 8'hFF, 8'h30);

    for (int r = 0; r < 4; r++) begin
      rp = 8'($urandom); rm = 8'($urandom); rv = 8'($urandom);
`ifdef PROBE_CAPTURE_QUAL_EN
      rv[0] = 1'b1;
`endif
      run($sformatf("rnd%0d", r), rp, rm, rv);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
